// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU codes, opcode/funct values, immediate
// extension modes, and the ID/EX register layout.
package pipe_pkg;

  // ALU control codes (3'b011 is intentionally unused)
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_ADDC = 3'b001;
  localparam logic [2:0] ALU_OR   = 3'b010;
  localparam logic [2:0] ALU_SUB  = 3'b100;
  localparam logic [2:0] ALU_SUBC = 3'b101;
  localparam logic [2:0] ALU_SLT  = 3'b110;
  localparam logic [2:0] ALU_SLTU = 3'b111;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // R-type function codes
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [1:0] {
    EXT_SIGN  = 2'd0,
    EXT_ZERO  = 2'd1,
    EXT_UPPER = 2'd2
  } ext_mode_e;

  // Contents of the ID/EX register; all-zero is both the reset and bubble value
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [2:0]  alu_ctr;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm_ext;
    logic        use_imm;
    logic        a_zero;
    logic        wen;
    logic [4:0]  waddr;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        illegal;
  } ex_reg_t;

  // Widen the 16-bit immediate according to the instruction's extension mode
  function automatic logic [31:0] extend_imm(input logic [15:0] imm, input ext_mode_e mode);
    logic [31:0] r;
    case (mode)
      EXT_ZERO:  r = {16'h0000, imm};
      EXT_UPPER: r = {imm, 16'h0000};
      default:   r = {{16{imm[15]}}, imm};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decoder: opcode/funct to ALU code and execute-stage controls.
module alu_ctrl_dec
  import pipe_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctr,
  output ext_mode_e  ext_mode,
  output logic       use_imm,
  output logic       wen,
  output logic       dest_rd,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch,
  output logic       uses_rt,
  output logic       illegal
);

  // Decode the instruction; unknown encodings fall through to an illegal no-op
  always_comb begin
    alu_ctr   = ALU_ADD;
    ext_mode  = EXT_SIGN;
    use_imm   = 1'b0;
    wen       = 1'b0;
    dest_rd   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    uses_rt   = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        wen     = 1'b1;
        dest_rd = 1'b1;
        uses_rt = 1'b1;
        case (funct)
          FN_ADDU: alu_ctr = ALU_ADD;
          FN_ADD:  alu_ctr = ALU_ADDC;
          FN_OR:   alu_ctr = ALU_OR;
          FN_SUBU: alu_ctr = ALU_SUB;
          FN_SUB:  alu_ctr = ALU_SUBC;
          FN_SLT:  alu_ctr = ALU_SLT;
          FN_SLTU: alu_ctr = ALU_SLTU;
          default: begin
            wen     = 1'b0;
            dest_rd = 1'b0;
            uses_rt = 1'b0;
            illegal = 1'b1;
          end
        endcase
      end
      OP_ADDIU: begin
        use_imm = 1'b1;
        wen     = 1'b1;
      end
      OP_ORI: begin
        alu_ctr  = ALU_OR;
        ext_mode = EXT_ZERO;
        use_imm  = 1'b1;
        wen      = 1'b1;
      end
      OP_LUI: begin
        alu_ctr  = ALU_OR;
        ext_mode = EXT_UPPER;
        use_imm  = 1'b1;
        wen      = 1'b1;
      end
      OP_LW: begin
        use_imm  = 1'b1;
        wen      = 1'b1;
        mem_read = 1'b1;
      end
      OP_SW: begin
        use_imm   = 1'b1;
        mem_write = 1'b1;
        uses_rt   = 1'b1;
      end
      OP_BEQ: begin
        alu_ctr = ALU_SUB;
        branch  = 1'b1;
        uses_rt = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-operand forwarding and load-use stall detection.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [31:0] id_pc,
  input  logic [5:0]  id_opcode,
  input  logic [5:0]  id_funct,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [31:0] id_rs_val,
  input  logic [31:0] id_rt_val,
  input  logic [15:0] id_imm,
  input  logic        flush,
  input  logic        exm_wen,
  input  logic [4:0]  exm_waddr,
  input  logic [31:0] exm_wdata,
  input  logic        mwb_wen,
  input  logic [4:0]  mwb_waddr,
  input  logic [31:0] mwb_wdata,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctr,
  output logic        ex_valid,
  output logic        ex_wen,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_illegal,
  output logic [4:0]  ex_waddr,
  output logic [31:0] ex_store_data,
  output logic [31:0] ex_pc,
  output logic        stall
);

  ex_reg_t     ex_reg;
  ex_reg_t     ex_next;

  logic [2:0]  dec_alu_ctr;
  ext_mode_e   dec_ext_mode;
  logic        dec_use_imm;
  logic        dec_wen;
  logic        dec_dest_rd;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_branch;
  logic        dec_uses_rt;
  logic        dec_illegal;
  logic [4:0]  dest;
  logic        dest_wen;
  logic [31:0] fwd_rs;
  logic [31:0] fwd_rt;

  alu_ctrl_dec u_dec (
    .opcode    (id_opcode),
    .funct     (id_funct),
    .alu_ctr   (dec_alu_ctr),
    .ext_mode  (dec_ext_mode),
    .use_imm   (dec_use_imm),
    .wen       (dec_wen),
    .dest_rd   (dec_dest_rd),
    .mem_read  (dec_mem_read),
    .mem_write (dec_mem_write),
    .branch    (dec_branch),
    .uses_rt   (dec_uses_rt),
    .illegal   (dec_illegal)
  );

  // Newest writer wins; register 0 is hard-wired and never forwarded
  function automatic logic [31:0] forward(
    input logic [4:0]  idx,
    input logic [31:0] reg_val,
    input logic        e_wen,
    input logic [4:0]  e_addr,
    input logic [31:0] e_data,
    input logic        m_wen,
    input logic [4:0]  m_addr,
    input logic [31:0] m_data
  );
    logic [31:0] r;
    if (idx != 5'd0 && e_wen && e_addr == idx)
      r = e_data;
    else if (idx != 5'd0 && m_wen && m_addr == idx)
      r = m_data;
    else
      r = reg_val;
    return r;
  endfunction

  // Build the value loaded on a normal capture; non-writers carry waddr 0
  always_comb begin
    dest     = dec_dest_rd ? id_rd : id_rt;
    dest_wen = dec_wen && (dest != 5'd0);
    ex_next           = '0;
    ex_next.valid     = id_valid;
    ex_next.pc        = id_pc;
    ex_next.alu_ctr   = dec_alu_ctr;
    ex_next.rs        = id_rs;
    ex_next.rt        = id_rt;
    ex_next.rs_val    = id_rs_val;
    ex_next.rt_val    = id_rt_val;
    ex_next.imm_ext   = extend_imm(id_imm, dec_ext_mode);
    ex_next.use_imm   = dec_use_imm;
    ex_next.a_zero    = (dec_ext_mode == EXT_UPPER);
    ex_next.wen       = dest_wen;
    ex_next.waddr     = dest_wen ? dest : 5'd0;
    ex_next.mem_read  = dec_mem_read;
    ex_next.mem_write = dec_mem_write;
    ex_next.branch    = dec_branch;
    ex_next.illegal   = dec_illegal;
  end

  // Pipeline register: reset/flush clear, stall inserts an all-zero bubble
  always_ff @(posedge clk) begin
    if (rst || flush || stall)
      ex_reg <= '0;
    else
      ex_reg <= ex_next;
  end

  // Load-use hazard: the loaded value is not available until the load leaves MEM
  always_comb begin
    stall = ex_reg.valid && ex_reg.mem_read && (ex_reg.waddr != 5'd0) && id_valid &&
            ((ex_reg.waddr == id_rs) || ((ex_reg.waddr == id_rt) && dec_uses_rt));
  end

  // Operand selection with forwarding from EX/MEM and MEM/WB
  always_comb begin
    fwd_rs = forward(ex_reg.rs, ex_reg.rs_val, exm_wen, exm_waddr, exm_wdata,
                     mwb_wen, mwb_waddr, mwb_wdata);
    fwd_rt = forward(ex_reg.rt, ex_reg.rt_val, exm_wen, exm_waddr, exm_wdata,
                     mwb_wen, mwb_waddr, mwb_wdata);
    alu_a         = ex_reg.a_zero ? 32'h0 : fwd_rs;
    alu_b         = ex_reg.use_imm ? ex_reg.imm_ext : fwd_rt;
    ex_store_data = fwd_rt;
  end

  assign alu_ctr      = ex_reg.alu_ctr;
  assign ex_valid     = ex_reg.valid;
  assign ex_wen       = ex_reg.wen;
  assign ex_mem_read  = ex_reg.mem_read;
  assign ex_mem_write = ex_reg.mem_write;
  assign ex_branch    = ex_reg.branch;
  assign ex_illegal   = ex_reg.illegal;
  assign ex_waddr     = ex_reg.waddr;
  assign ex_pc        = ex_reg.pc;

endmodule
